fifo_wr_arbiter: RTL

Round-robin arbiter that shares the single write port of the async FIFO among NREQ write-domain requesters. A grant is held for one packet, delimited by a per-requester last flag and capped at MAX_BURST beats. Beats are gated by the FIFO's registered full flag. The block sits entirely in the write clock domain, directly in front of the FIFO write-pointer logic, and drives its w_en and write data.

---
 rtl/fifo_pkg.sv | 34 +++
 rtl/fifo_wr_arbiter_if.sv | 25 ++
 rtl/rr_priority_pick.sv | 38 +++
 rtl/fifo_wr_arbiter.sv | 117 +++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO write-side (and read-side) schedulers.
package fifo_pkg;

  localparam int NREQ_MAX = 8;
  localparam int IDX_W    = 3;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Round-robin winner: first set bit of req searching upward from last_winner+1, wrapping at n.
  // Returns last_winner unchanged when nothing is requesting.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ_MAX-1:0] req,
                                               input logic [IDX_W-1:0]    last_winner,
                                               input int                  n);
    logic [IDX_W-1:0] w;
    int c;
    w = last_winner;
    for (int k = n; k >= 1; k--) begin
      c = (int'(last_winner) + k) % n;
      if (req[c[IDX_W-1:0]]) w = c[IDX_W-1:0];
    end
    return w;
  endfunction

  function automatic logic [NREQ_MAX-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NREQ_MAX-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side bundle of the write arbiter. master = arbiter, slave = requesters + FIFO.
interface fifo_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    last;
  logic [NREQ*DW-1:0] data;
  logic               full;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    acc;
  logic               w_en;
  logic [DW-1:0]      w_data;
  logic               busy;

  modport master (
    input  req, last, data, full,
    output gnt, acc, w_en, w_data, busy
  );

  modport slave (
    output req, last, data, full,
    input  gnt, acc, w_en, w_data, busy
  );
endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: rotate req so last_winner+1 sits at bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module rr_priority_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_winner,
  output logic [IW-1:0]   winner,
  output logic            valid
);

  logic [NREQ-1:0] rot;
  logic [IW-1:0]   src;
  logic [IW-1:0]   k;
  logic            found;

  // rotate, encode, unrotate
  always_comb begin
    rot    = '0;
    src    = '0;
    k      = '0;
    found  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      src    = IW'((int'(last_winner) + 1 + i) % NREQ);
      rot[i] = req[src];
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        k     = IW'(i);
      end
    end
    valid  = |rot;
    winner = IW'((int'(last_winner) + 1 + int'(k)) % NREQ);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of the async FIFO write pointer logic.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ARB_IDLE  | no owner; pick next requester (1-cycle arbitration bubble)
//   ARB_GRANT | owner holds the write port until last, burst cap or withdraw
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 8
) (
  input  logic               w_clk,
  input  logic               wrst_n,
  fifo_wr_arbiter_if.master  bus
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  arb_state_e          state_q, state_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [IW-1:0]       lw_q, lw_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       pick;
  logic                pick_valid;
  logic [NREQ_MAX-1:0] pick_oh;
  logic                req_o;
  logic                last_o;
  logic [DW-1:0]       data_o;
  logic                beat;
  logic                rel;

  rr_priority_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req         (bus.req),
    .last_winner (lw_q),
    .winner      (pick),
    .valid       (pick_valid)
  );

  assign pick_oh = onehot(IDX_W'(pick));

  if (NREQ < NREQ_MAX) begin : g_unused
    logic unused_oh;
    assign unused_oh = ^pick_oh[NREQ_MAX-1:NREQ];
  end

  // last_winner doubles as the owner index while in GRANT
  always_comb begin
    req_o  = 1'b0;
    last_o = 1'b0;
    data_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (lw_q == IW'(i)) begin
        req_o  = bus.req[i];
        last_o = bus.last[i];
        data_o = bus.data[i*DW +: DW];
      end
    end
  end

  assign beat        = (state_q == ARB_GRANT) & req_o & ~bus.full;
  assign rel         = (beat & last_o) | (beat & (cnt_q == CW'(MAX_BURST - 1))) | ~req_o;
  assign bus.w_en    = beat;
  assign bus.acc     = beat ? gnt_q : '0;
  assign bus.w_data  = beat ? data_o : '0;
  assign bus.gnt     = gnt_q;
  assign bus.busy    = (state_q == ARB_GRANT);

  // next-state, grant, burst counter
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    lw_d    = lw_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d = ARB_GRANT;
          gnt_d   = pick_oh[NREQ-1:0];
          lw_d    = pick;
          cnt_d   = '0;
        end
      end
      ARB_GRANT: begin
        if (beat) cnt_d = cnt_q + 1'b1;
        if (rel) begin
          state_d = ARB_IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // state registers; reset gives requester 0 first priority
  always_ff @(posedge w_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      lw_q    <= IW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      lw_q    <= lw_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
